// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the unified memory port.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;

    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic              ls_err;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_err, ls_rdata,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_ack, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_err, ls_rdata,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_ack, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store: grants in IDLE, drives the
// request until acked, waits for the response (with timeout) and returns it to the owner.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic              own_ls;
        logic              we;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            r_state, w_next;
    req_t              r_req;
    logic              r_err;
    logic [DATA_W-1:0] r_data;
    logic [SW-1:0]     r_streak;
    logic [TW-1:0]     r_tmo;

    logic              w_ls_mis, w_if_mis, w_starve, w_ls_win, w_if_win, w_tmo_hit;
    logic [DATA_W-1:0] w_mask;

    always_comb begin
        w_ls_mis = 1'b0;
        case (bus.ls_size)
            2'd0:    w_ls_mis = 1'b0;
            2'd1:    w_ls_mis = bus.ls_addr[0];
            2'd2:    w_ls_mis = |bus.ls_addr[1:0];
            default: w_ls_mis = |bus.ls_addr[2:0];
        endcase
    end

    assign w_if_mis  = |bus.if_addr[1:0];
    // Fetch jumps the queue once load/store has won MAX_STREAK times in a row over it
    assign w_starve  = bus.if_req && (r_streak == SW'(MAX_STREAK));
    assign w_ls_win  = reset && (r_state == S_IDLE) && bus.ls_req && !w_starve;
    assign w_if_win  = reset && (r_state == S_IDLE) && bus.if_req && !w_ls_win;
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ls_win)      w_next = w_ls_mis ? S_RESP : S_BUSY;
                else if (w_if_win) w_next = w_if_mis ? S_RESP : S_BUSY;
            end
            S_BUSY:  if (bus.mem_ack) w_next = S_WAIT;
            S_WAIT:  if (bus.mem_rvalid || w_tmo_hit) w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req    <= '0;
            r_err    <= 1'b0;
            r_data   <= '0;
            r_streak <= '0;
            r_tmo    <= '0;
        end else begin
            if (w_ls_win) begin
                r_req    <= '{own_ls: 1'b1, we: bus.ls_we, size: bus.ls_size,
                              addr: bus.ls_addr, wdata: bus.ls_wdata};
                r_err    <= w_ls_mis;
                r_data   <= '0;
                if (!bus.if_req)                        r_streak <= '0;
                else if (r_streak != SW'(MAX_STREAK))   r_streak <= r_streak + 1'b1;
            end else if (w_if_win) begin
                r_req    <= '{own_ls: 1'b0, we: 1'b0, size: 2'd2,
                              addr: bus.if_addr, wdata: '0};
                r_err    <= w_if_mis;
                r_data   <= '0;
                r_streak <= '0;
            end
            if (r_state == S_BUSY) r_tmo <= '0;
            if (r_state == S_WAIT) begin
                r_tmo <= r_tmo + 1'b1;
                if (bus.mem_rvalid)  r_data <= bus.mem_rdata;
                else if (w_tmo_hit)  r_err  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_mask = '1;
        case (r_req.size)
            2'd0:    w_mask = DATA_W'(8'hFF);
            2'd1:    w_mask = DATA_W'(16'hFFFF);
            2'd2:    w_mask = DATA_W'(32'hFFFF_FFFF);
            default: w_mask = '1;
        endcase
    end

    always_comb begin
        bus.if_gnt    = w_if_win;
        bus.ls_gnt    = w_ls_win;
        bus.if_rvalid = 1'b0;
        bus.if_err    = 1'b0;
        bus.if_rdata  = '0;
        bus.ls_rvalid = 1'b0;
        bus.ls_err    = 1'b0;
        bus.ls_rdata  = '0;
        bus.mem_req   = (r_state == S_BUSY);
        bus.mem_we    = r_req.we;
        bus.mem_size  = r_req.size;
        bus.mem_addr  = r_req.addr;
        bus.mem_wdata = r_req.wdata;
        if (r_state == S_RESP) begin
            if (r_req.own_ls) begin
                bus.ls_rvalid = 1'b1;
                bus.ls_err    = r_err;
                if (!r_err && !r_req.we) bus.ls_rdata = r_data & w_mask;
            end else begin
                bus.if_rvalid = 1'b1;
                bus.if_err    = r_err;
                if (!r_err) bus.if_rdata = r_data[31:0];
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized transactions on the memory port arbiter, checked against a
// transaction-level model of grant priority, alignment, masking and response timing.
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MS = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int streak = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] trim(input logic [63:0] d, input logic [1:0] s);
        int nb;
        nb = 1 << s;
        if (nb == 8) return d;
        return d & ((64'd1 << (8 * nb)) - 64'd1);
    endfunction

    function automatic logic any_out();
        return |{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_err,
                 bus.ls_gnt, bus.ls_rvalid, bus.ls_err, bus.ls_rdata,
                 bus.mem_req, bus.mem_we, bus.mem_size, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic chk_resp(input bit lw, input bit err, input logic [63:0] data);
        chk("resp_flags", 64'({bus.if_rvalid, bus.if_err, bus.ls_rvalid, bus.ls_err}),
            64'({!lw, !lw && err, lw, lw && err}));
        chk("if_rdata", 64'(bus.if_rdata), lw ? 64'd0 : 64'(data[31:0]));
        chk("ls_rdata", bus.ls_rdata, lw ? data : 64'd0);
    endtask

    // rv_dly < 0 means memory never answers
    task automatic run(input bit ir, input logic [63:0] ia, input bit lr, input bit we,
                       input logic [1:0] sz, input logic [63:0] la, input logic [63:0] wd,
                       input int ack_dly, input int rv_dly, input logic [63:0] rd,
                       output bit won_ls);
        bit lw, iw, mis, tmo;
        logic [63:0] e_addr, e_wd, e_data;
        logic [2:0] e_ctl;
        int ew;
        lw = lr && !(ir && streak == MS);
        iw = ir && !lw;
        if (lw) streak = ir ? ((streak + 1 > MS) ? MS : streak + 1) : 0;
        else if (iw) streak = 0;

        @(negedge clk);
        bus.if_req = ir;  bus.if_addr = ia;
        bus.ls_req = lr;  bus.ls_we = we; bus.ls_size = sz; bus.ls_addr = la; bus.ls_wdata = wd;
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0;
        #1;
        chk("if_gnt", 64'(bus.if_gnt), 64'(iw));
        chk("ls_gnt", 64'(bus.ls_gnt), 64'(lw));
        won_ls = lw;
        if (lw) begin
            e_ctl = {we, sz}; e_addr = la; e_wd = wd;
            mis = (la % (64'd1 << sz)) != 64'd0;
        end else begin
            e_ctl = 3'b010; e_addr = ia; e_wd = 64'd0;
            mis = (ia % 64'd4) != 64'd0;
        end

        @(negedge clk);
        if (lw) bus.ls_req = 1'b0; else bus.if_req = 1'b0;
        if (mis) begin
            #1;
            chk("mis_no_memreq", 64'(bus.mem_req), 64'd0);
            chk_resp(lw, 1'b1, 64'd0);
        end else begin
            for (int k = 0; k <= ack_dly; k++) begin
                if (k > 0) @(negedge clk);
                bus.mem_ack = (k == ack_dly);
                #1;
                chk("mem_req", 64'(bus.mem_req), 64'd1);
                chk("mem_addr", bus.mem_addr, e_addr);
                chk("mem_ctl", 64'({bus.mem_we, bus.mem_size}), 64'(e_ctl));
                chk("mem_wdata", bus.mem_wdata, e_wd);
                chk("held_off", 64'({bus.if_gnt, bus.ls_gnt}), 64'd0);
            end
            tmo = !(rv_dly >= 0 && rv_dly <= TO - 1);
            ew = tmo ? TO : rv_dly + 1;
            if (tmo) e_data = 64'd0;
            else if (lw) e_data = we ? 64'd0 : trim(rd, sz);
            else e_data = 64'(rd[31:0]);
            for (int w = 0; w <= ew; w++) begin
                @(negedge clk);
                bus.mem_ack = 1'b0;
                bus.mem_rvalid = (w == rv_dly);
                bus.mem_rdata = rd;
                #1;
                if (w == 0) chk("memreq_drop", 64'(bus.mem_req), 64'd0);
                if (w < ew) begin
                    chk("no_early_resp", 64'({bus.if_rvalid, bus.ls_rvalid, bus.if_gnt, bus.ls_gnt}), 64'd0);
                end else chk_resp(lw, tmo, e_data);
            end
            bus.mem_rvalid = 1'b0;
        end
    endtask

    initial begin
        bit wl;
        logic [9:0] seq;
        bus.if_req = 1'b1; bus.if_addr = 64'h10;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = 2'd0; bus.ls_addr = '0; bus.ls_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        repeat (3) @(negedge clk);
        #1 chk("reset_outs", 64'(any_out()), 64'd0);
        @(posedge clk); #2 reset = 1'b1;

        run(1, 64'h10, 0, 0, 2'd0, 64'h0, 64'h0, 0, 0, 64'hAABBCCDD_11223344, wl);
        run(0, 64'h0, 1, 0, 2'd0, 64'h7, 64'h0, 1, 2, 64'hFFFF_FFFF_FFFF_FF85, wl);
        run(0, 64'h0, 1, 0, 2'd1, 64'h3, 64'h0, 0, 0, 64'h0, wl);
        run(0, 64'h0, 1, 1, 2'd3, 64'h100, 64'h0123_4567_89AB_CDEF, 2, 1, 64'hDEAD_BEEF_0000_1111, wl);
        run(1, 64'h22, 0, 0, 2'd0, 64'h0, 64'h0, 0, 0, 64'h0, wl);

        seq = 10'b1111011110;
        for (int i = 0; i < 10; i++) begin
            run(1, 64'h200 + 64'(4 * i), 1, 0, 2'd2, 64'h400 + 64'(8 * i), 64'h0, 0, 0,
                {$urandom, $urandom}, wl);
            chk("streak_seq", 64'(wl), 64'(seq[9 - i]));
        end

        run(0, 64'h0, 1, 0, 2'd3, 64'h808, 64'h0, 3, -1, 64'h0, wl);
        @(negedge clk); bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h5555; #1;
        chk("late_rv_idle", 64'({bus.if_rvalid, bus.ls_rvalid}), 64'd0);
        @(negedge clk); bus.mem_rvalid = 1'b0; #1;
        chk("late_rv_ignored", 64'({bus.if_rvalid, bus.ls_rvalid}), 64'd0);

        @(negedge clk);
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd3; bus.ls_addr = 64'h40; #1;
        chk("rstw_gnt", 64'(bus.ls_gnt), 64'd1);
        @(negedge clk); bus.ls_req = 1'b0; bus.mem_ack = 1'b1;
        @(negedge clk); bus.mem_ack = 1'b0;
        @(negedge clk); reset = 1'b0; streak = 0; #1;
        chk("rst_wait_outs", 64'(any_out()), 64'd0);
        @(negedge clk); reset = 1'b1; bus.mem_rvalid = 1'b1; #1;
        chk("rst_late_rv", 64'({bus.if_rvalid, bus.ls_rvalid}), 64'd0);
        @(negedge clk); bus.mem_rvalid = 1'b0; #1;
        chk("rst_no_resp", 64'({bus.if_rvalid, bus.ls_rvalid, bus.mem_req}), 64'd0);
        run(1, 64'h3C, 0, 0, 2'd0, 64'h0, 64'h0, 1, 1, 64'hCAFE_F00D_1234_5678, wl);

        for (int t = 0; t < 40; t++) begin
            bit ir, lr, we;
            logic [1:0] sz;
            logic [63:0] la, ia;
            int rv;
            ir = 1'($urandom_range(0, 1));
            lr = 1'($urandom_range(0, 1));
            if (!ir && !lr) lr = 1'b1;
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            la = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) la = la & ~((64'd1 << sz) - 64'd1);
            ia = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) ia = ia & ~64'd3;
            rv = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
            run(ir, ia, lr, we, sz, la, {$urandom, $urandom}, $urandom_range(0, 3), rv,
                {$urandom, $urandom}, wl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
